// File: rtl/alu_result_buffer.sv
// ALU result skid buffer: 2-entry FIFO, one-cycle accept-to-output latency, out_* driven from registers only.
// in_ready is registered (count<2); commits update the NZIV status and the sticky V/I bits.
module alu_result_buffer #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [31:0]       in_flags,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wr_en,
  input  logic              in_set_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wr_en,
  output logic [3:0]        status_nziv,
  output logic              sticky_v,
  output logic              sticky_i,
  input  logic              clr_sticky,
  output logic [1:0]        count
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [RD_W-1:0]   rd;
    logic              wr_en;
    logic [3:0]        nziv;
    logic              set_flags;
  } entry_t;

  entry_t     head_q;
  entry_t     skid_q;
  entry_t     in_ent;
  logic [1:0] count_q;
  logic [1:0] count_nxt;
  logic       in_ready_q;
  logic       accept;
  logic       commit;
  logic       set_commit;
  logic       unused_flags;

  // Only the NZIV nibble is kept; the low flag bits are deliberately dropped.
  assign unused_flags = ^in_flags[27:0];

  always_comb begin
    in_ent           = '0;
    in_ent.result    = in_result;
    in_ent.rd        = in_rd;
    in_ent.wr_en     = in_wr_en;
    in_ent.nziv      = in_flags[31:28];
    in_ent.set_flags = in_set_flags;
  end

  assign out_valid  = (count_q != 2'd0);
  assign accept     = in_valid & in_ready_q;
  assign commit     = out_valid & out_ready;
  assign set_commit = commit & head_q.set_flags;

  always_comb begin
    count_nxt = count_q;
    if (accept && !commit) begin
      count_nxt = count_q + 2'd1;
    end else if (commit && !accept) begin
      count_nxt = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      skid_q      <= '0;
      count_q     <= 2'd0;
      in_ready_q  <= 1'b1;
      status_nziv <= 4'b0100;
      sticky_v    <= 1'b0;
      sticky_i    <= 1'b0;
    end else begin
      count_q    <= count_nxt;
      in_ready_q <= (count_nxt != 2'd2);
      case ({accept, commit})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_q <= in_ent;
          end else begin
            skid_q <= in_ent;
          end
        end
        2'b01: begin
          // Draining to empty leaves head untouched so out_* hold their last values.
          if (count_q == 2'd2) begin
            head_q <= skid_q;
          end
        end
        // Both at once only happens with one entry held: the newcomer replaces it.
        2'b11:   head_q <= in_ent;
        default: ;
      endcase
      if (set_commit) begin
        status_nziv <= head_q.nziv;
      end
      // A bit being set this cycle beats a concurrent clear.
      sticky_v <= (sticky_v & ~clr_sticky) | (set_commit & head_q.nziv[0]);
      sticky_i <= (sticky_i & ~clr_sticky) | (set_commit & head_q.nziv[1]);
    end
  end

  assign in_ready   = in_ready_q;
  assign count      = count_q;
  assign out_result = head_q.result;
  assign out_rd     = head_q.rd;
  assign out_wr_en  = head_q.wr_en;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Randomized plus directed checks of alu_result_buffer against a queue-based reference model.
module tb_alu_result_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [31:0] in_flags;
  logic [3:0]  in_rd;
  logic        in_wr_en;
  logic        in_set_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_rd;
  logic        out_wr_en;
  logic [3:0]  status_nziv;
  logic        sticky_v;
  logic        sticky_i;
  logic        clr_sticky;
  logic [1:0]  count;

  always #5 clk = ~clk;

  alu_result_buffer #(.DATA_W(32), .RD_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_flags(in_flags), .in_rd(in_rd), .in_wr_en(in_wr_en), .in_set_flags(in_set_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wr_en(out_wr_en),
    .status_nziv(status_nziv), .sticky_v(sticky_v), .sticky_i(sticky_i),
    .clr_sticky(clr_sticky), .count(count)
  );

  typedef struct {
    logic [31:0] result;
    logic [3:0]  rd;
    logic        wr;
    logic [3:0]  nziv;
    logic        set;
  } ent_t;

  ent_t        q[$];
  ent_t        last_out;
  logic [3:0]  m_status;
  logic        m_sv;
  logic        m_si;
  logic        last_acc;
  logic [31:0] commit_log[$];
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_out = '{default: 0};
    m_status = 4'b0100;
    m_sv     = 1'b0;
    m_si     = 1'b0;
  endtask

  task automatic check_all();
    check("count", count, q.size());
    check("in_ready", in_ready, q.size() < 2);
    check("out_valid", out_valid, q.size() > 0);
    check("out_result", out_result, last_out.result);
    check("out_rd", out_rd, last_out.rd);
    check("out_wr_en", out_wr_en, last_out.wr);
    check("status", status_nziv, m_status);
    check("sticky_v", sticky_v, m_sv);
    check("sticky_i", sticky_i, m_si);
  endtask

  // Called just after a falling edge: check, drive, clock once, advance the model.
  task automatic step(input logic iv, input logic [31:0] res, input logic [31:0] fl,
                      input logic [3:0] rd, input logic wr, input logic set,
                      input logic ordy, input logic clr, input logic r);
    logic acc;
    logic com;
    logic hit;
    ent_t e;
    ent_t h;
    check_all();
    in_valid = iv; in_result = res; in_flags = fl; in_rd = rd;
    in_wr_en = wr; in_set_flags = set; out_ready = ordy; clr_sticky = clr; rst = r;
    acc = iv && (q.size() < 2) && !r;
    com = ordy && (q.size() > 0) && !r;
    if (ordy && out_valid && !r) commit_log.push_back(out_result);
    e = '{result: res, rd: rd, wr: wr, nziv: fl[31:28], set: set};
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      hit = 1'b0;
      if (com) begin
        h = q.pop_front();
        hit = h.set;
        if (h.set) m_status = h.nziv;
      end
      m_sv = (clr ? 1'b0 : m_sv) | (hit && h.nziv[0]);
      m_si = (clr ? 1'b0 : m_si) | (hit && h.nziv[1]);
      if (acc) q.push_back(e);
      if (q.size() > 0) last_out = q[0];
    end
    last_acc = acc;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] bp_exp[3];
  bit          c_in;
  int          log_base;

  initial begin
    bp_exp = '{32'h11, 32'h22, 32'h33};
    rst = 1'b1; in_valid = 0; in_result = 0; in_flags = 0; in_rd = 0;
    in_wr_en = 0; in_set_flags = 0; out_ready = 0; clr_sticky = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_status", status_nziv, 4'b0100);

    // single op
    step(1, 32'h5, 32'h0, 4'd3, 1, 1, 1, 0, 0);
    check("single_vld", out_valid, 1);
    check("single_res", out_result, 32'h5);
    check("single_rd", out_rd, 3);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("single_status", status_nziv, 4'b0000);

    // backpressure and ordered release
    commit_log.delete();
    step(1, 32'h11, 0, 4'd1, 1, 0, 0, 0, 0);
    step(1, 32'h22, 0, 4'd2, 1, 0, 0, 0, 0);
    check("bp_count", count, 2);
    check("bp_in_ready", in_ready, 0);
    step(1, 32'h33, 0, 4'd3, 1, 0, 0, 0, 0);
    check("bp_hold_count", count, 2);
    c_in = 0;
    for (int i = 0; i < 10 && (q.size() > 0 || !c_in); i++) begin
      step(!c_in, 32'h33, 0, 4'd3, 1, 0, 1, 0, 0);
      if (last_acc) c_in = 1;
    end
    check("bp_commits", commit_log.size(), 3);
    for (int i = 0; i < 3; i++)
      check("bp_order", (i < commit_log.size()) ? commit_log[i] : 32'hdead_beef, bp_exp[i]);

    // streaming at count=1
    step(1, 32'h100, 0, 4'd4, 1, 0, 0, 0, 0);
    log_base = commit_log.size();
    for (int i = 0; i < 8; i++) begin
      step(1, 32'h101 + i, 0, 4'd5, 1, 0, 1, 0, 0);
      check("stream_count", count, 1);
      check("stream_in_ready", in_ready, 1);
    end
    check("stream_rate", commit_log.size() - log_base, 8);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);

    // flags: setting commit then non-setting commit
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(1, 32'h1, 32'h9000_0000, 4'd6, 1, 1, 0, 0, 0);
    step(1, 32'h2, 32'h2000_0000, 4'd7, 1, 0, 1, 0, 0);
    check("flags_status1", status_nziv, 4'b1001);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("flags_status2", status_nziv, 4'b1001);
    check("flags_sticky_v", sticky_v, 1);

    // sticky set beats same-cycle clear
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    check("race_pre", sticky_v, 0);
    step(1, 32'h3, 32'h1000_0000, 4'd8, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    check("race_set", sticky_v, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("race_clr", sticky_v, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 79) == 0);

    // reset while full: nothing commits
    step(0, 0, 0, 0, 0, 0, 1, 1, 1);
    step(1, 32'haa, 32'hF000_0000, 4'd9, 1, 1, 0, 0, 0);
    step(1, 32'hbb, 32'hF000_0000, 4'd10, 1, 1, 0, 0, 0);
    check("rstmid_full", count, 2);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    check("rstmid_count", count, 0);
    check("rstmid_valid", out_valid, 0);
    check("rstmid_status", status_nziv, 4'b0100);
    check("rstmid_sticky", sticky_v, 0);
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
